// File: rtl/valid_ready_pipeline.sv
// valid_ready_pipeline: depth-stage valid/ready register pipeline with a
// combinational ready chain, so internal bubbles collapse and up to depth
// transfers are held. Optional flush support is compiled in by defining
// VALID_READY_PIPELINE_FLUSH_EN; otherwise the flush port is ignored.
module valid_ready_pipeline #(
    parameter int width = 8,
    parameter int depth = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_vld,
    output logic                         in_rdy,
    input  logic [width-1:0]             in_data,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [width-1:0]             out_data,
    output logic [$clog2(depth+1)-1:0]   count
);

    localparam int CW = $clog2(depth + 1);

    logic [depth-1:0] vld_q;
    logic [depth-1:0] vld_d;
    logic [depth-1:0] stage_free;
    logic [width-1:0] data_q [depth];
    logic [width-1:0] data_d [depth];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             flush_act;
    logic             in_take;

`ifdef VALID_READY_PIPELINE_FLUSH_EN
    assign flush_act = flush;
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign flush_act    = 1'b0;
`endif

    // Ready chain: a stage is free if it is empty or everything downstream can move.
    always_comb begin
        stage_free = '0;
        stage_free[depth-1] = !vld_q[depth-1] || out_rdy;
        for (int i = depth - 2; i >= 0; i--) begin
            stage_free[i] = !vld_q[i] || stage_free[i+1];
        end
    end

    assign in_rdy   = stage_free[0] && !flush_act;
    assign out_vld  = vld_q[depth-1] && !flush_act;
    assign out_data = data_q[depth-1];
    assign count    = count_q;
    assign in_take  = in_vld && in_rdy;

    // Next state: free stages pull from upstream, data only moves with a valid bit.
    always_comb begin
        vld_d = vld_q;
        for (int i = 0; i < depth; i++) begin
            data_d[i] = data_q[i];
        end
        if (stage_free[0]) begin
            vld_d[0] = in_take;
            if (in_take) begin
                data_d[0] = in_data;
            end
        end
        for (int i = 1; i < depth; i++) begin
            if (stage_free[i]) begin
                vld_d[i] = vld_q[i-1];
                if (vld_q[i-1]) begin
                    data_d[i] = data_q[i-1];
                end
            end
        end
        if (flush_act) begin
            vld_d = '0;
        end
        count_d = '0;
        for (int i = 0; i < depth; i++) begin
            count_d = count_d + CW'(vld_d[i]);
        end
    end

    // Valid bits and occupancy count; reset empties the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= '0;
            count_q <= '0;
        end else begin
            vld_q   <= vld_d;
            count_q <= count_d;
        end
    end

    // Payload registers carry no reset; they are meaningless while invalid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < depth; i++) begin
            data_q[i] <= data_d[i];
        end
    end

endmodule

// File: tb/tb_valid_ready_pipeline.sv
// Directed self-checking bench for valid_ready_pipeline (width 8, depth 4).
// Flush expectations follow VALID_READY_PIPELINE_FLUSH_EN.
module tb_valid_ready_pipeline;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_vld;
    logic       in_rdy;
    logic [7:0] in_data;
    logic       out_vld;
    logic       out_rdy;
    logic [7:0] out_data;
    logic [2:0] count;

    int tests_run;
    int tests_failed;

    valid_ready_pipeline #(.width(8), .depth(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .count    (count)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        flush   = 1'b0;
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        in_data = 8'h00;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        flush   = 1'b0;
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        in_data = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        #1;
        tests_run++;
        if (out_vld !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_out_vld: got %0b expected 0", out_vld);
        end
        tests_run++;
        if (count !== 3'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_count: got %0d expected 0", count);
        end
        tests_run++;
        if (in_rdy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_in_rdy: got %0b expected 1", in_rdy);
        end
    endtask

    task automatic test_stream();
        logic [7:0] exp_data;
        logic [2:0] exp_count;
        do_reset();
        in_vld  = 1'b1;
        out_rdy = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            in_data = 8'(k);
            #1;
            tests_run++;
            if (in_rdy !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL stream_in_rdy k=%0d: got %0b expected 1", k, in_rdy);
            end
            tick();
            exp_count = (k < 4) ? 3'(k) : 3'd4;
            tests_run++;
            if (count !== exp_count) begin
                tests_failed++;
                $display("[TB] FAIL stream_count k=%0d: got %0d expected %0d", k, count, exp_count);
            end
            tests_run++;
            if (out_vld !== (k >= 4)) begin
                tests_failed++;
                $display("[TB] FAIL stream_out_vld k=%0d: got %0b expected %0b", k, out_vld, (k >= 4));
            end
            if (k >= 4) begin
                exp_data = 8'(k - 3);
                tests_run++;
                if (out_data !== exp_data) begin
                    tests_failed++;
                    $display("[TB] FAIL stream_out_data k=%0d: got %0h expected %0h", k, out_data, exp_data);
                end
            end
        end
        in_vld = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            if (j < 3) begin
                exp_data = 8'(8 + j);
                tests_run++;
                if (out_vld !== 1'b1 || out_data !== exp_data) begin
                    tests_failed++;
                    $display("[TB] FAIL stream_drain j=%0d: got vld=%0b data=%0h expected vld=1 data=%0h", j, out_vld, out_data, exp_data);
                end
            end else begin
                tests_run++;
                if (out_vld !== 1'b0 || count !== 3'd0) begin
                    tests_failed++;
                    $display("[TB] FAIL stream_empty: got vld=%0b count=%0d expected vld=0 count=0", out_vld, count);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_data;
        do_reset();
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            in_data = 8'(k);
            #1;
            tests_run++;
            if (in_rdy !== (k <= 4)) begin
                tests_failed++;
                $display("[TB] FAIL bp_in_rdy k=%0d: got %0b expected %0b", k, in_rdy, (k <= 4));
            end
            tick();
        end
        tests_run++;
        if (count !== 3'd4) begin
            tests_failed++;
            $display("[TB] FAIL bp_full_count: got %0d expected 4", count);
        end
        tests_run++;
        if (out_vld !== 1'b1 || out_data !== 8'h01) begin
            tests_failed++;
            $display("[TB] FAIL bp_head: got vld=%0b data=%0h expected vld=1 data=1", out_vld, out_data);
        end
        // Full and both sides transfer: one in, one out.
        out_rdy = 1'b1;
        #1;
        tests_run++;
        if (in_rdy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL full_in_rdy_follows_out_rdy: got %0b expected 1", in_rdy);
        end
        tick();
        in_vld = 1'b0;
        tests_run++;
        if (count !== 3'd4) begin
            tests_failed++;
            $display("[TB] FAIL full_passthrough_count: got %0d expected 4", count);
        end
        for (int j = 0; j < 4; j++) begin
            exp_data = 8'(2 + j);
            tests_run++;
            if (out_vld !== 1'b1 || out_data !== exp_data) begin
                tests_failed++;
                $display("[TB] FAIL bp_order j=%0d: got vld=%0b data=%0h expected vld=1 data=%0h", j, out_vld, out_data, exp_data);
            end
            tick();
        end
        tests_run++;
        if (out_vld !== 1'b0 || count !== 3'd0) begin
            tests_failed++;
            $display("[TB] FAIL bp_drained: got vld=%0b count=%0d expected vld=0 count=0", out_vld, count);
        end
    endtask

    task automatic test_bubbles();
        logic [7:0] exp_data;
        do_reset();
        out_rdy = 1'b0;
        for (int k = 0; k < 8; k++) begin
            in_vld  = (k % 2 == 0);
            in_data = 8'(8'h10 + k);
            tick();
        end
        in_vld = 1'b0;
        #1;
        tests_run++;
        if (count !== 3'd4) begin
            tests_failed++;
            $display("[TB] FAIL bubble_count: got %0d expected 4", count);
        end
        tests_run++;
        if (in_rdy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bubble_in_rdy: got %0b expected 0", in_rdy);
        end
        out_rdy = 1'b1;
        for (int j = 0; j < 4; j++) begin
            exp_data = 8'(8'h10 + 2 * j);
            tests_run++;
            if (out_vld !== 1'b1 || out_data !== exp_data) begin
                tests_failed++;
                $display("[TB] FAIL bubble_order j=%0d: got vld=%0b data=%0h expected vld=1 data=%0h", j, out_vld, out_data, exp_data);
            end
            tick();
        end
        tests_run++;
        if (out_vld !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bubble_drained: got %0b expected 0", out_vld);
        end
    endtask

    task automatic test_flush();
        logic       exp_in_rdy;
        logic       exp_out_vld;
        logic [2:0] exp_count;
        do_reset();
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            in_data = 8'(8'h20 + k);
            tick();
        end
        in_vld = 1'b0;
        tick();
        tests_run++;
        if (count !== 3'd3 || out_vld !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL flush_setup: got count=%0d vld=%0b expected count=3 vld=1", count, out_vld);
        end
`ifdef VALID_READY_PIPELINE_FLUSH_EN
        exp_in_rdy  = 1'b0;
        exp_out_vld = 1'b0;
        exp_count   = 3'd0;
`else
        exp_in_rdy  = 1'b1;
        exp_out_vld = 1'b1;
        exp_count   = 3'd4;
`endif
        flush   = 1'b1;
        in_vld  = 1'b1;
        in_data = 8'h99;
        #1;
        tests_run++;
        if (in_rdy !== exp_in_rdy) begin
            tests_failed++;
            $display("[TB] FAIL flush_in_rdy: got %0b expected %0b", in_rdy, exp_in_rdy);
        end
        tests_run++;
        if (out_vld !== exp_out_vld) begin
            tests_failed++;
            $display("[TB] FAIL flush_out_vld: got %0b expected %0b", out_vld, exp_out_vld);
        end
        tick();
        flush  = 1'b0;
        in_vld = 1'b0;
        #1;
        tests_run++;
        if (count !== exp_count) begin
            tests_failed++;
            $display("[TB] FAIL flush_count: got %0d expected %0d", count, exp_count);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            in_data = 8'(8'h40 + k);
            tick();
        end
        tests_run++;
        if (count !== 3'd3) begin
            tests_failed++;
            $display("[TB] FAIL midrst_setup: got %0d expected 3", count);
        end
        rst     = 1'b1;
        in_vld  = 1'b1;
        in_data = 8'h55;
        out_rdy = 1'b1;
        tick();
        rst    = 1'b0;
        in_vld = 1'b0;
        #1;
        tests_run++;
        if (count !== 3'd0 || out_vld !== 1'b0 || in_rdy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midrst_clear: got count=%0d vld=%0b rdy=%0b expected 0 0 1", count, out_vld, in_rdy);
        end
        for (int j = 0; j < 4; j++) begin
            tick();
        end
        tests_run++;
        if (count !== 3'd0 || out_vld !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_discard: got count=%0d vld=%0b expected count=0 vld=0", count, out_vld);
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        flush        = 1'b0;
        in_vld       = 1'b0;
        out_rdy      = 1'b0;
        in_data      = 8'h00;
        test_reset();
        test_stream();
        test_backpressure();
        test_bubbles();
        test_flush();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/valid_ready_pipeline.md
VALID_READY_PIPELINE -- requirements
Module: valid_ready_pipeline

Interface
REQ-001 The block SHALL have parameter width, default 8, meaning data bits per transfer (width >= 1).
REQ-002 The block SHALL have parameter depth, default 8, meaning number of register stages (depth >= 1).
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, meaning reset; it is synchronous and active-high.
REQ-005 The block SHALL have port flush, input, 1 bit, meaning discard all held transfers; present in every build.
REQ-006 The block SHALL have port in_vld, input, 1 bit, meaning upstream offers in_data this cycle.
REQ-007 The block SHALL have port in_rdy, output, 1 bit, meaning the block accepts in_data this cycle.
REQ-008 The block SHALL have port in_data, input, width bits, meaning the upstream payload.
REQ-009 The block SHALL have port out_vld, output, 1 bit, meaning out_data holds a valid transfer.
REQ-010 The block SHALL have port out_rdy, input, 1 bit, meaning downstream accepts out_data this cycle.
REQ-011 The block SHALL have port out_data, output, width bits, meaning the payload of the last stage.
REQ-012 The block SHALL have port count, output, $clog2(depth+1) bits, meaning number of valid stages.

Function
REQ-013 Each stage i SHALL hold one valid bit and one width-bit data register; stage 0 faces input, stage depth-1 drives out_data and out_vld.
REQ-014 A transfer SHALL occur at input when in_vld && in_rdy, and at output when out_vld && out_rdy.
REQ-015 Stage depth-1 SHALL be free when its valid bit is 0 or out_rdy is 1; stage i < depth-1 SHALL be free when its valid bit is 0 or stage i+1 is free.
REQ-016 in_rdy SHALL equal "stage 0 free"; ready is a combinational chain from out_rdy, so internal bubbles are collapsed and the pipeline holds up to depth transfers.
REQ-017 A free stage i SHALL load data and valid from stage i-1 (or from in_data/in_vld&&in_rdy for i=0); a non-free stage SHALL hold.
REQ-018 Data registers SHALL load only when the incoming valid bit is 1; on a bubble only the valid bit is cleared.
REQ-019 With out_rdy held 1, a transfer accepted at edge N SHALL appear on out_vld/out_data after edge N+depth-1 (latency depth cycles from acceptance to visibility).
REQ-020 Transfer order SHALL be preserved; no transfer may be duplicated or dropped except by flush or rst.
REQ-021 count SHALL equal the number of set stage valid bits, updated each edge; count = depth implies in_rdy = out_rdy.
REQ-022 Simultaneous input and output transfer when full SHALL keep count at depth.
REQ-023 in_rdy and out_vld SHALL not depend combinationally on in_vld.

Reset
REQ-024 While rst is 1 at an edge, all stage valid bits SHALL clear, giving out_vld = 0, count = 0, in_rdy = 1 after that edge.
REQ-025 Data registers SHALL not be reset; out_data is don't-care while out_vld = 0.
REQ-026 rst SHALL take priority over flush and any transfer in the same cycle; reset mid-stream discards all held transfers.

Configuration
REQ-027 Macro VALID_READY_PIPELINE_FLUSH_EN SHALL compile in flush support.
REQ-028 With the macro defined, flush = 1 SHALL force in_rdy = 0 and out_vld = 0 that cycle and clear all valid bits at the edge (count = 0 next cycle).
REQ-029 Without the macro, the flush port SHALL be ignored and behaviour SHALL be as if flush were always 0.

Verification
REQ-030 depth=4, rst then in_vld=1 with data 1,2,3,... every cycle, out_rdy=1 -> out_vld first 1 four cycles after first acceptance, out_data 1,2,3,... one per cycle, count steady 4.
REQ-031 depth=4, out_rdy=0, push 5 transfers -> 4 accepted, in_rdy=0 after the fourth, count=4; raise out_rdy -> outputs 1,2,3,4,5 in order.
REQ-032 depth=4, alternate in_vld 1/0 with out_rdy=0 for 8 cycles -> bubbles collapse, count reaches 4, in_rdy=0.
REQ-033 Full pipeline, in_vld=1, out_rdy=1 same cycle -> one in, one out, count stays 4, no loss.
REQ-034 FLUSH_EN defined, count=3, flush pulse -> out_vld=0 and in_rdy=0 during pulse, count=0 after; without macro same stimulus -> no effect.
REQ-035 rst asserted with count=3 and in_vld=1 -> after edge count=0, out_vld=0, input transfer discarded.
